// File: rtl/ccc_seq_pkg.sv
// Shared types and defaults for the CCC/PLL lock sequencer.
// CCC_SEQ_APB_CFG_EN adds the APB configuration-write states.
package ccc_seq_pkg;

  localparam int PWRDN_CYCLES_D = 16;
  localparam int ARST_CYCLES_D  = 8;
  localparam int LOCK_TIMEOUT_D = 4096;
  localparam int LOCK_STABLE_D  = 256;
  localparam int LOSS_FILTER_D  = 4;
  localparam int MAX_RETRY_D    = 3;

  localparam int APB_AW = 6;
  localparam int APB_DW = 8;

  typedef enum logic [2:0] {
    S_PWRDN,
    S_ARST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAULT
`ifdef CCC_SEQ_APB_CFG_EN
    ,
    S_CFG_SETUP,
    S_CFG_ACCESS
`endif
  } state_t;

endpackage

// File: rtl/ccc_seq_lock_filter.sv
// LOCK synchronizer with consecutive-high (stable) and consecutive-low (lost)
// qualification; each counter is held clear while its owning state is inactive.
module ccc_seq_lock_filter #(
  parameter int LOCK_STABLE = 256,
  parameter int LOSS_FILTER = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic lock_async,
  input  logic clr_hi,
  input  logic clr_lo,
  output logic lock_sync,
  output logic stable,
  output logic lost
);

  localparam int HI_W = $clog2(LOCK_STABLE + 1);
  localparam int LO_W = $clog2(LOSS_FILTER + 1);
  localparam logic [HI_W-1:0] HI_LAST = HI_W'(LOCK_STABLE - 1);
  localparam logic [LO_W-1:0] LO_LAST = LO_W'(LOSS_FILTER - 1);

  logic [1:0]      sync;
  logic [HI_W-1:0] hi_cnt;
  logic [LO_W-1:0] lo_cnt;

  assign lock_sync = sync[1];
  // Strobes fire on the last qualifying cycle so the FSM moves on the next edge.
  assign stable    = lock_sync && (hi_cnt == HI_LAST);
  assign lost      = !lock_sync && (lo_cnt == LO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync   <= '0;
      hi_cnt <= '0;
      lo_cnt <= '0;
    end else begin
      sync <= {sync[0], lock_async};
      if (clr_hi || !lock_sync)  hi_cnt <= '0;
      else if (hi_cnt != HI_LAST) hi_cnt <= hi_cnt + HI_W'(1);
      if (clr_lo || lock_sync)   lo_cnt <= '0;
      else if (lo_cnt != LO_LAST) lo_cnt <= lo_cnt + LO_W'(1);
    end
  end

endmodule

// File: rtl/ccc_lock_sequencer.sv
// Power-up/lock supervisor for the fabric CCC/PLL; all outputs registered from next state.
// Define CCC_SEQ_APB_CFG_EN to build the CCC APB configuration-write path.
module ccc_lock_sequencer
  import ccc_seq_pkg::*;
#(
  parameter int PWRDN_CYCLES = PWRDN_CYCLES_D,
  parameter int ARST_CYCLES  = ARST_CYCLES_D,
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_D,
  parameter int LOCK_STABLE  = LOCK_STABLE_D,
  parameter int LOSS_FILTER  = LOSS_FILTER_D,
  parameter int MAX_RETRY    = MAX_RETRY_D
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              LOCK,
  input  logic              LOCK_LOST_CLR,
`ifdef CCC_SEQ_APB_CFG_EN
  input  logic              CFG_REQ,
  input  logic [APB_AW-1:0] CFG_ADDR,
  input  logic [APB_DW-1:0] CFG_DATA,
  input  logic              CCC_BUSY,
  output logic              CFG_ACK,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [APB_AW-1:0] PADDR,
  output logic [APB_DW-1:0] PWDATA,
`endif
  output logic              PLL_POWERDOWN_N,
  output logic              PLL_ARST_N,
  output logic              FABRIC_RESET_N,
  output logic              READY,
  output logic              FAULT,
  output logic [1:0]        RETRY_CNT,
  output logic              LOCK_LOST
);

  localparam int CNT_MAX_A = (PWRDN_CYCLES > ARST_CYCLES) ? PWRDN_CYCLES : ARST_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > LOCK_TIMEOUT) ? CNT_MAX_A : LOCK_TIMEOUT;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             retry_inc;
  logic             lock_sync, stable, lost;

  ccc_seq_lock_filter #(
    .LOCK_STABLE (LOCK_STABLE),
    .LOSS_FILTER (LOSS_FILTER)
  ) u_filter (
    .clk        (CLK),
    .reset      (RESET),
    .lock_async (LOCK),
    .clr_hi     (state != S_STABLE),
    .clr_lo     (state != S_RUN),
    .lock_sync  (lock_sync),
    .stable     (stable),
    .lost       (lost)
  );

  always_comb begin
    state_nxt = state;
    retry_inc = 1'b0;
    case (state)
      S_PWRDN:
        if (cnt == CNT_W'(PWRDN_CYCLES - 1)) state_nxt = S_ARST;
      S_ARST:
        if (cnt == CNT_W'(ARST_CYCLES - 1)) state_nxt = S_WAIT_LOCK;
      S_WAIT_LOCK:
        if (lock_sync) state_nxt = S_STABLE;
        else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
          if (RETRY_CNT == 2'(MAX_RETRY)) state_nxt = S_FAULT;
          else begin
            state_nxt = S_ARST;
            retry_inc = 1'b1;
          end
        end
      S_STABLE:
        if (!lock_sync)  state_nxt = S_WAIT_LOCK;
        else if (stable) state_nxt = S_RUN;
      // Lock loss outranks a pending config request; the request stays pending.
      S_RUN:
        if (lost) state_nxt = S_ARST;
`ifdef CCC_SEQ_APB_CFG_EN
        else if (CFG_REQ) state_nxt = S_CFG_SETUP;
      S_CFG_SETUP:  state_nxt = S_CFG_ACCESS;
      S_CFG_ACCESS: if (!CCC_BUSY) state_nxt = S_ARST;
`endif
      S_FAULT:      state_nxt = S_FAULT;
      default:      state_nxt = S_PWRDN;
    endcase
  end

  // One counter serves PWRDN/ARST/WAIT_LOCK; any state change restarts it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state           <= S_PWRDN;
      cnt             <= '0;
      RETRY_CNT       <= '0;
      LOCK_LOST       <= 1'b0;
      PLL_POWERDOWN_N <= 1'b0;
      PLL_ARST_N      <= 1'b0;
      FABRIC_RESET_N  <= 1'b0;
      READY           <= 1'b0;
      FAULT           <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || state == S_RUN || state == S_FAULT) cnt <= '0;
      else cnt <= cnt + CNT_W'(1);
      if (state_nxt == S_RUN) RETRY_CNT <= '0;
      else if (retry_inc)     RETRY_CNT <= RETRY_CNT + 2'd1;
      if (state == S_RUN && lost) LOCK_LOST <= 1'b1;
      else if (LOCK_LOST_CLR)     LOCK_LOST <= 1'b0;
      PLL_POWERDOWN_N <= !(state_nxt == S_PWRDN || state_nxt == S_FAULT);
      PLL_ARST_N      <= !(state_nxt == S_PWRDN || state_nxt == S_ARST || state_nxt == S_FAULT);
      FABRIC_RESET_N  <= (state_nxt == S_RUN);
      READY           <= (state_nxt == S_RUN);
      FAULT           <= (state_nxt == S_FAULT);
    end
  end

`ifdef CCC_SEQ_APB_CFG_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      CFG_ACK <= 1'b0;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
    end else begin
      if (state == S_RUN && state_nxt == S_CFG_SETUP) begin
        PADDR  <= CFG_ADDR;
        PWDATA <= CFG_DATA;
      end
      PSEL    <= (state_nxt == S_CFG_SETUP) || (state_nxt == S_CFG_ACCESS);
      PWRITE  <= (state_nxt == S_CFG_SETUP) || (state_nxt == S_CFG_ACCESS);
      PENABLE <= (state_nxt == S_CFG_ACCESS);
      CFG_ACK <= (state == S_CFG_ACCESS) && (state_nxt == S_ARST);
    end
  end
`endif

endmodule

// File: tb/tb_ccc_lock_sequencer.sv
// Directed bench for ccc_lock_sequencer; edge numbers count from the last reset edge.
// The APB section is built only when CCC_SEQ_APB_CFG_EN is defined.
module tb_ccc_lock_sequencer;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       LOCK = 1'b0;
  logic       LOCK_LOST_CLR = 1'b0;
  logic       PLL_POWERDOWN_N, PLL_ARST_N, FABRIC_RESET_N, READY, FAULT, LOCK_LOST;
  logic [1:0] RETRY_CNT;
`ifdef CCC_SEQ_APB_CFG_EN
  logic       CFG_REQ = 1'b0;
  logic [5:0] CFG_ADDR = '0;
  logic [7:0] CFG_DATA = '0;
  logic       CCC_BUSY = 1'b0;
  logic       CFG_ACK, PSEL, PENABLE, PWRITE;
  logic [5:0] PADDR;
  logic [7:0] PWDATA;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  ccc_lock_sequencer dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .LOCK            (LOCK),
    .LOCK_LOST_CLR   (LOCK_LOST_CLR),
`ifdef CCC_SEQ_APB_CFG_EN
    .CFG_REQ         (CFG_REQ),
    .CFG_ADDR        (CFG_ADDR),
    .CFG_DATA        (CFG_DATA),
    .CCC_BUSY        (CCC_BUSY),
    .CFG_ACK         (CFG_ACK),
    .PSEL            (PSEL),
    .PENABLE         (PENABLE),
    .PWRITE          (PWRITE),
    .PADDR           (PADDR),
    .PWDATA          (PWDATA),
`endif
    .PLL_POWERDOWN_N (PLL_POWERDOWN_N),
    .PLL_ARST_N      (PLL_ARST_N),
    .FABRIC_RESET_N  (FABRIC_RESET_N),
    .READY           (READY),
    .FAULT           (FAULT),
    .RETRY_CNT       (RETRY_CNT),
    .LOCK_LOST       (LOCK_LOST)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Leaves time just after edge 0, the last edge that samples RESET high.
  task automatic do_reset();
    RESET = 1'b1;
    tick(3);
    RESET = 1'b0;
  endtask

  initial begin
    // Reset values and PWRDN/ARST timing
    do_reset();
    chk("rst_pwrdn_n", PLL_POWERDOWN_N, 0);
    chk("rst_arst_n",  PLL_ARST_N, 0);
    chk("rst_fabric",  FABRIC_RESET_N, 0);
    chk("rst_ready",   READY, 0);
    chk("rst_fault",   FAULT, 0);
    chk("rst_retry",   RETRY_CNT, 0);
    chk("rst_lost",    LOCK_LOST, 0);
    tick(15); chk("pwrdn_e15",   PLL_POWERDOWN_N, 0);
    tick(1);  chk("pwrdn_e16",   PLL_POWERDOWN_N, 1);
              chk("arst_e16",    PLL_ARST_N, 0);
    tick(7);  chk("arst_e23",    PLL_ARST_N, 0);
    tick(1);  chk("arst_e24",    PLL_ARST_N, 1);

    // Clean lock: LOCK rises after edge 100 -> STABLE at 103, RUN at 359
    tick(76); LOCK = 1'b1;
    tick(258); chk("clean_ready_e358", READY, 0);
    tick(1);   chk("clean_ready_e359", READY, 1);
               chk("clean_fabric",     FABRIC_RESET_N, 1);
               chk("clean_retry",      RETRY_CNT, 0);

    // 3-cycle glitch is filtered
    LOCK = 1'b0; tick(3); LOCK = 1'b1; tick(10);
    chk("glitch3_ready", READY, 1);
    chk("glitch3_lost",  LOCK_LOST, 0);

    // 4-cycle glitch: loss decided 6 edges after the drop; set beats a held clear
    LOCK = 1'b0; LOCK_LOST_CLR = 1'b1;
    tick(4); LOCK = 1'b1;
    tick(1); chk("glitch4_ready_k5", READY, 1);
    tick(1); chk("glitch4_ready_k6", READY, 0);
             chk("glitch4_fabric",   FABRIC_RESET_N, 0);
             chk("glitch4_lost",     LOCK_LOST, 1);
             chk("glitch4_arst",     PLL_ARST_N, 0);
             chk("glitch4_pwrdn_n",  PLL_POWERDOWN_N, 1);
    LOCK_LOST_CLR = 1'b0;
    tick(1); chk("lost_sticky", LOCK_LOST, 1);
    LOCK_LOST_CLR = 1'b1;
    tick(1); LOCK_LOST_CLR = 1'b0;
    chk("lost_cleared", LOCK_LOST, 0);
    tick(300); chk("relock_ready", READY, 1);

    // Chatter in STABLE: lock seen low at stable count 200, fresh 256 needed
    LOCK = 1'b0;
    do_reset();
    tick(24);  LOCK = 1'b1;
    tick(201); LOCK = 1'b0;
    tick(5);   LOCK = 1'b1;
    tick(53);  chk("chatter_ready_e283", READY, 0);
    tick(205); chk("chatter_ready_e488", READY, 0);
    tick(1);   chk("chatter_ready_e489", READY, 1);

`ifdef CCC_SEQ_APB_CFG_EN
    // APB write with 3 busy cycles in access
    do_reset();
    tick(300); chk("apb_pre_ready", READY, 1);
    CFG_REQ = 1'b1; CFG_ADDR = 6'h2A; CFG_DATA = 8'h5C; CCC_BUSY = 1'b1;
    tick(1);
    chk("apb_setup_psel",  PSEL, 1);
    chk("apb_setup_pen",   PENABLE, 0);
    chk("apb_setup_pwr",   PWRITE, 1);
    chk("apb_setup_addr",  PADDR, 6'h2A);
    chk("apb_setup_data",  PWDATA, 8'h5C);
    chk("apb_setup_ready", READY, 0);
    chk("apb_setup_fab",   FABRIC_RESET_N, 0);
    CFG_REQ = 1'b0; CFG_ADDR = '0; CFG_DATA = '0;
    tick(1); chk("apb_acc_pen",  PENABLE, 1);
    tick(3); chk("apb_hold_pen", PENABLE, 1);
             chk("apb_hold_addr", PADDR, 6'h2A);
             chk("apb_hold_data", PWDATA, 8'h5C);
             chk("apb_hold_ack",  CFG_ACK, 0);
    CCC_BUSY = 1'b0;
    tick(1); chk("apb_ack",       CFG_ACK, 1);
             chk("apb_done_psel", PSEL, 0);
             chk("apb_done_pen",  PENABLE, 0);
             chk("apb_done_arst", PLL_ARST_N, 0);
    tick(1); chk("apb_ack_pulse", CFG_ACK, 0);
    tick(300); chk("apb_relock", READY, 1);

    // RESET in the middle of an access
    CFG_REQ = 1'b1; CFG_ADDR = 6'h11; CFG_DATA = 8'hA5; CCC_BUSY = 1'b1;
    tick(1); CFG_REQ = 1'b0;
    tick(2); chk("apbrst_pen_pre", PENABLE, 1);
    RESET = 1'b1;
    tick(1); chk("apbrst_psel",    PSEL, 0);
             chk("apbrst_pen",     PENABLE, 0);
             chk("apbrst_addr",    PADDR, 0);
             chk("apbrst_pwrdn_n", PLL_POWERDOWN_N, 0);
    CCC_BUSY = 1'b0;
`endif

    // Timeout retries into FAULT, LOCK tied low
    LOCK = 1'b0;
    do_reset();
    tick(4119); chk("tmo_retry_e4119",  RETRY_CNT, 0);
    tick(1);    chk("tmo_retry_e4120",  RETRY_CNT, 1);
                chk("tmo_arst_e4120",   PLL_ARST_N, 0);
    tick(4103); chk("tmo_retry_e8223",  RETRY_CNT, 1);
    tick(1);    chk("tmo_retry_e8224",  RETRY_CNT, 2);
    tick(4104); chk("tmo_retry_e12328", RETRY_CNT, 3);
    tick(4103); chk("tmo_fault_e16431", FAULT, 0);
    tick(1);    chk("tmo_fault_e16432", FAULT, 1);
                chk("tmo_pwrdn_n",      PLL_POWERDOWN_N, 0);
                chk("tmo_retry_fault",  RETRY_CNT, 3);
    LOCK = 1'b1;
    tick(400);  chk("fault_held",       FAULT, 1);
                chk("fault_ready",      READY, 0);
    do_reset(); chk("fault_rst_fault",  FAULT, 0);
                chk("fault_rst_retry",  RETRY_CNT, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
